// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_IALU   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6
  } cls_e;

  // Opcode field values (instruction bits [6:2])
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode classifier; JAL is only recognised when enabled.
module cu_opcode_decode
  import cu_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic [4:0] opcode,
  output cls_e       cls,
  output logic       legal
);

  // Map opcode to instruction class; anything unknown stays CLS_NONE
  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    if (ENABLE_JAL) cls = CLS_JAL;
      default:   cls = CLS_NONE;
    endcase
  end

  assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeout, hold freeze and a trap state for illegal opcodes / timeouts.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          ENABLE_JAL  = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic       mem_ready,
  input  logic       hold,
  input  logic       trap_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  // Last count value before the timeout fires (count reaches MEM_TIMEOUT)
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_reg, state_next;
  cls_e             cls_reg, cls_next, dec_cls;
  logic             dec_legal;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic             frozen;
  logic             go;

  cu_opcode_decode #(.ENABLE_JAL(ENABLE_JAL)) u_decode (
    .opcode (opcode),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  // hold freezes every sequencing state; IDLE and TRAP ignore it
  assign frozen = hold && (state_reg != ST_IDLE) && (state_reg != ST_TRAP);
  assign go     = ~frozen;

  // State, latched class, wait counter and trap cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cls_reg   <= CLS_NONE;
      cnt_reg   <= '0;
      cause_reg <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      cls_reg   <= cls_next;
      cnt_reg   <= cnt_next;
      cause_reg <= cause_next;
    end
  end

  // Next-state sequencing and datapath control outputs
  always_comb begin
    state_next = state_reg;
    cls_next   = cls_reg;
    cause_next = cause_reg;
    cnt_next   = frozen ? cnt_reg : '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    mem_to_reg = M2R_ALU;
    reg_write  = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH, ST_MEM: begin
        mem_req = 1'b1;
        if (state_reg == ST_FETCH) begin
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready & go;
          pc_write  = mem_ready & go;
        end else begin
          iord   = 1'b1;
          mem_we = (cls_reg == CLS_STORE) & go;
        end
        if (!frozen) begin
          if (mem_ready) begin
            if (state_reg == ST_FETCH)    state_next = ST_DECODE;
            else if (cls_reg == CLS_STORE) state_next = ST_FETCH;
            else                           state_next = ST_WB;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
        if (!frozen) begin
          if (dec_legal) begin
            cls_next   = dec_cls;
            state_next = ST_EXEC;
          end else begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        end
      end
      ST_EXEC: begin
        case (cls_reg)
          CLS_R:      begin alu_src_a = 1'b1; alu_src_b = SRCB_RS2; alu_op = ALU_RFUNCT; end
          CLS_IALU:   begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALU_IFUNCT; end
          CLS_LOAD,
          CLS_STORE:  begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALU_ADD; end
          CLS_BRANCH: begin alu_src_a = 1'b1; alu_src_b = SRCB_RS2; alu_op = ALU_SUB; branch = go; end
          CLS_JAL:    begin jump = go; pc_write = go; end
          default:    ;
        endcase
        if (!frozen) begin
          case (cls_reg)
            CLS_LOAD, CLS_STORE:       state_next = ST_MEM;
            CLS_R, CLS_IALU, CLS_JAL:  state_next = ST_WB;
            default:                   state_next = ST_FETCH;
          endcase
        end
      end
      ST_WB: begin
        reg_write = go;
        if (cls_reg == CLS_LOAD)     mem_to_reg = M2R_MDR;
        else if (cls_reg == CLS_JAL) mem_to_reg = M2R_PC;
        if (!frozen) state_next = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
        if (trap_ack) begin
          state_next = ST_FETCH;
          cause_next = CAUSE_NONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign trap_cause = cause_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_multicycle_control_unit;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic       mem_ready, hold, trap_ack;
  logic       mem_req, mem_we, iord, ir_write, pc_write, branch, jump, alu_src_a;
  logic [1:0] alu_src_b, alu_op, mem_to_reg, trap_cause;
  logic       reg_write, trap;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int stall = 0;
  int idx;
  logic [4:0] ops [6] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011};

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .ENABLE_JAL(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
    .trap_ack(trap_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .jump(jump),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle,1 fetch,2 decode,3 exec,4 mem,5 wb,6 trap
  // kind : 0 none,1 R,2 IALU,3 LOAD,4 STORE,5 BRANCH,6 JAL
  int m_st = 0, m_cls = 0, m_wait = 0, m_cause = 0;

  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b01100: return 1;
      5'b00100: return 2;
      5'b00000: return 3;
      5'b01000: return 4;
      5'b11000: return 5;
      5'b11011: return 6;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [20:0] expect_out(input int st, input int cls, input int cause,
                                             input logic rdy, input logic hld);
    logic go;
    logic req, we, ad, irw, pcw, br, jmp, a, rw, tr;
    logic [1:0] b, op, m2r, tc;
    go = (st == 0 || st == 6) ? 1'b1 : !hld;
    {req, we, ad, irw, pcw, br, jmp, a, rw, tr} = '0;
    b = 2'd0; op = 2'd0; m2r = 2'd0; tc = 2'd0;
    case (st)
      1: begin req = 1; b = 2'd1; irw = rdy & go; pcw = rdy & go; end
      2: b = 2'd2;
      3: case (cls)
           1: begin a = 1; b = 2'd0; op = 2'd2; end
           2: begin a = 1; b = 2'd2; op = 2'd3; end
           3, 4: begin a = 1; b = 2'd2; op = 2'd0; end
           5: begin a = 1; b = 2'd0; op = 2'd1; br = go; end
           6: begin jmp = go; pcw = go; end
           default: ;
         endcase
      4: begin req = 1; ad = 1; we = (cls == 4) & go; end
      5: begin rw = go; m2r = (cls == 3) ? 2'd1 : (cls == 6) ? 2'd2 : 2'd0; end
      6: begin tr = 1; tc = 2'(cause); end
      default: ;
    endcase
    return {req, we, ad, irw, pcw, br, jmp, a, b, op, m2r, rw, tr, tc, 3'(st)};
  endfunction

  // Advance the model on each clock edge from the spec's sequencing rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_cls <= 0; m_wait <= 0; m_cause <= 0;
    end else if (hold && m_st != 0 && m_st != 6) begin
      m_st <= m_st;
    end else begin
      case (m_st)
        0: m_st <= 1;
        1, 4: begin
          if (mem_ready) begin
            m_wait <= 0;
            if (m_st == 1)      m_st <= 2;
            else if (m_cls == 4) m_st <= 1;
            else                 m_st <= 5;
          end else if (m_wait + 1 >= TO) begin
            m_wait <= 0; m_st <= 6; m_cause <= 2;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        2: if (classify(opcode) == 0) begin m_st <= 6; m_cause <= 1; end
           else begin m_cls <= classify(opcode); m_st <= 3; end
        3: m_st <= (m_cls == 5) ? 1 : (m_cls == 3 || m_cls == 4) ? 4 : 5;
        5: m_st <= 1;
        6: if (trap_ack) begin m_st <= 1; m_cause <= 0; end
        default: m_st <= 0;
      endcase
    end
  end

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    logic [20:0] exp_v, act_v;
    exp_v = expect_out(m_st, m_cls, m_cause, mem_ready, hold);
    act_v = {mem_req, mem_we, iord, ir_write, pc_write, branch, jump, alu_src_a,
             alu_src_b, alu_op, mem_to_reg, reg_write, trap, trap_cause, state};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model_compare t=%0t got=%h expected=%h", $time, act_v, exp_v);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic hld, input logic ack, input int exp_st);
    mem_ready = rdy; hold = hld; trap_ack = ack;
    #1;
    chk("dut_state", int'(state), exp_st);
    chk("model_state", m_st, exp_st);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic rdy, input logic hld, input logic ack, input int exp_st);
    drive(rdy, hld, ack, exp_st);
    adv();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; opcode = 5'b01100; mem_ready = 1'b0; hold = 1'b0; trap_ack = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'({mem_req, mem_we, iord, ir_write, pc_write, branch, jump,
        alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, trap, trap_cause}), 0);
    adv();
    rst_n = 1'b1;

    // R-type, zero wait: 0,1,2,3,5,1
    step(1, 0, 0, 0);
    drive(1, 0, 0, 1); chk("r_ir_write", int'(ir_write), 1); adv();
    step(1, 0, 0, 2);
    drive(1, 0, 0, 3); chk("r_alu_op", int'(alu_op), 2); chk("r_no_rw_exec", int'(reg_write), 0); adv();
    drive(1, 0, 0, 5); chk("r_reg_write", int'(reg_write), 1); adv();

    // LOAD with three MEM wait cycles: 8 cycles total
    opcode = 5'b00000;
    step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 4);
      chk("ld_mem_req", int'(mem_req), 1); chk("ld_iord", int'(iord), 1); chk("ld_mem_we", int'(mem_we), 0);
      adv();
    end
    step(1, 0, 0, 4);
    drive(1, 0, 0, 5); chk("ld_mem_to_reg", int'(mem_to_reg), 1); adv();

    // STORE: write strobe only in MEM, back to FETCH after 4 cycles
    opcode = 5'b01000;
    step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
    drive(1, 0, 0, 4); chk("st_mem_we", int'(mem_we), 1); chk("st_reg_write", int'(reg_write), 0); adv();

    // Illegal opcode trap and acknowledge
    opcode = 5'b11111;
    step(1, 0, 0, 1); step(1, 0, 0, 2);
    drive(0, 0, 0, 6); chk("ill_trap", int'(trap), 1); chk("ill_cause", int'(trap_cause), 1); adv();
    step(0, 0, 1, 6);

    // FETCH timeout after 15 non-ready cycles
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 1);
      if (i == 0) chk("ack_cause_clear", int'(trap_cause), 0);
      adv();
    end
    drive(0, 0, 0, 6); chk("to_cause", int'(trap_cause), 2); adv();
    step(0, 0, 1, 6);

    // Ready on the 15th cycle wins over the timeout; then BRANCH with hold
    opcode = 5'b11000;
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 3); chk("hold_branch", int'(branch), 0); adv();
    end
    drive(1, 0, 0, 3); chk("release_branch", int'(branch), 1); adv();
    step(1, 0, 0, 1);

    // Reset mid-MEM aborts immediately with all outputs low
    opcode = 5'b00000;
    step(1, 0, 0, 2); step(1, 0, 0, 3);
    drive(0, 0, 0, 4);
    rst_n = 1'b0; #1;
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_outputs", int'({mem_req, mem_we, iord, ir_write, pc_write, branch, jump,
        alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, trap, trap_cause}), 0);
    adv(); adv();
    rst_n = 1'b1;

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      idx = $urandom_range(0, 7);
      opcode = (idx < 6) ? ops[idx] : 5'($urandom);
      if (stall > 0) begin
        mem_ready = 1'b0; stall--;
      end else if ($urandom_range(0, 29) == 0) begin
        stall = $urandom_range(10, 24); mem_ready = 1'b0;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      hold = ($urandom_range(0, 7) == 0);
      trap_ack = ($urandom_range(0, 2) == 0);
      adv();
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- A Moore/Mealy FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB over a shared instruction/data memory port.
- Supports a ready/req memory handshake with timeout, a pipeline-freeze input, and an illegal-opcode/timeout trap.
- Drives the multi-cycle datapath muxes, register-file write enable and PC write enables.

Parameters:
- MEM_TIMEOUT, 15: mem_ready wait cycles tolerated in FETCH/MEM before trap; legal range 1..255.
- ENABLE_JAL, 1: 1 decodes JAL (opcode[6:2]=11011); 0 treats it as illegal.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  5  instruction bits [6:2] from the IR; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- hold  in  1  freeze FSM in its current state
- trap_ack  in  1  leave TRAP
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; only valid with mem_req
- iord  out  1  address select: 0=PC, 1=ALU result register
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load; datapath ANDs with zero
- jump  out  1  PC <- jump target
- alu_src_a  out  1  0=PC, 1=rs1
- alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
- alu_op  out  2  00=add, 01=sub/compare, 10=R-type funct, 11=I-type funct
- mem_to_reg  out  2  00=ALU, 01=MDR, 10=PC
- reg_write  out  1  register-file write
- trap  out  1  high while in TRAP
- trap_cause  out  2  01=illegal opcode, 10=memory timeout; held until trap_ack
- state  out  3  debug: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0; trap_cause=00; wait counter 0; latched class cleared.
  - IDLE lasts one cycle after reset deassertion, then goes to FETCH.
  - Reset mid-instruction aborts it with no write strobes.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - In the cycle mem_ready=1: ir_write=1 and pc_write=1 combinationally, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (branch target).
  - Classifies and latches opcode: 01100 R, 00100 IALU, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL (if ENABLE_JAL).
  - Any other opcode goes to TRAP with cause 01.
- EXEC, by latched class:
  - R: a=1, b=00, op=10; then WB.
  - IALU: a=1, b=10, op=11; then WB.
  - LOAD/STORE: a=1, b=10, op=00; then MEM.
  - BRANCH: a=1, b=00, op=01, branch=1; then FETCH.
  - JAL: jump=1, pc_write=1; then WB.
- MEM:
  - mem_req=1, iord=1, mem_we=(STORE).
  - On mem_ready: STORE goes to FETCH; LOAD goes to WB.
- WB:
  - reg_write=1; mem_to_reg=01 for LOAD, 10 for JAL, 00 otherwise; then FETCH.
- Minimum cycles per instruction (zero wait): BRANCH 3; R, IALU, STORE, JAL 4; LOAD 5.
- Wait counter:
  - Clears on entering FETCH/MEM and on mem_ready.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - When count reaches MEM_TIMEOUT with mem_ready still 0, goes to TRAP with cause 10.
  - mem_ready in that same cycle wins: no trap.
- hold:
  - In any state except IDLE/TRAP, the state and counter freeze.
  - pc_write, ir_write, reg_write, branch, jump and mem_we are forced to 0.
  - mem_req stays asserted, but mem_ready is ignored; memory must re-present it.
  - hold has priority over mem_ready and over the timeout.
- TRAP:
  - trap=1, all strobes 0.
  - trap_ack=1 clears trap_cause and goes to FETCH next cycle; trap_ack outside TRAP is ignored.
- Outputs are combinational from the registered state, latched class, mem_ready and hold; no output-to-input combinational path other than mem_ready/hold.

Decomposition:
- Package cu_pkg holds:
  - state enum
  - opcode constants
  - instruction-class enum
  - alu_op, alu_src_b and mem_to_reg encodings
- Sub-module cu_opcode_decode: combinational opcode-to-class and legal flag, with ENABLE_JAL passed through.

Test Plan:
- Reset released, R opcode 01100, mem_ready tied 1 -> state 0,1,2,3,5,1; reg_write=1 only in WB with alu_op=10 in EXEC.
- LOAD 00000, MEM waits 3 cycles -> MEM held 4 cycles with mem_req=1, iord=1, mem_we=0; WB has mem_to_reg=01; total 8 cycles.
- STORE 01000 -> mem_we=1 only in MEM; reg_write never 1; returns to FETCH after 4 cycles.
- Opcode 11111 -> DECODE then TRAP, trap_cause=01; trap_ack pulse -> FETCH next cycle, cause 00.
- FETCH with mem_ready=0 for 15 cycles (MEM_TIMEOUT=15) -> TRAP cause 10. Repeat with mem_ready=1 on the 15th cycle -> DECODE, no trap.
- hold=1 for 5 cycles in EXEC with BRANCH -> branch=0 and state stays 3 during hold; branch=1 in the release cycle; then FETCH. Separately, rst_n low mid-MEM -> IDLE immediately with all outputs 0.
